// File: rtl/datapath_pkg.sv
// Shared types for the parametrised datapath: ALU opcodes, flag bundle and
// the states of the iterative shifter.
package datapath_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_INC = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic cy;
        logic neg;
        logic zero;
        logic ovf;
    } flags_t;

    // IDLE: accepting work; SHIFT: one bit per cycle; WRITE: commit result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } sh_state_e;

endpackage

// File: rtl/datapath_param_alu_unit.sv
// Single-cycle combinational ALU. Arithmetic is done one bit wider than the
// word so the extra bit is the carry (or borrow for SUB). Shift opcodes pass
// A through unchanged; the real shifting is done by the iterative shifter.
module alu_unit
    import datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             cy_o,
    output logic             neg_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int M = WIDTH - 1;

    logic [WIDTH:0] wide;

    // Result, carry and signed overflow for the selected operation
    always_comb begin
        wide  = '0;
        res_o = a_i;
        cy_o  = 1'b0;
        ovf_o = 1'b0;
        case (alu_op_e'(op_i))
            OP_ADD: begin
                wide  = {1'b0, a_i} + {1'b0, b_i};
                res_o = wide[WIDTH-1:0];
                cy_o  = wide[WIDTH];
                ovf_o = (a_i[M] == b_i[M]) && (res_o[M] != a_i[M]);
            end
            OP_SUB: begin
                wide  = {1'b0, a_i} - {1'b0, b_i};
                res_o = wide[WIDTH-1:0];
                cy_o  = wide[WIDTH];
                ovf_o = (a_i[M] != b_i[M]) && (res_o[M] != a_i[M]);
            end
            OP_INC: begin
                wide  = {1'b0, a_i} + (WIDTH+1)'(1);
                res_o = wide[WIDTH-1:0];
                cy_o  = wide[WIDTH];
                ovf_o = ~a_i[M] & res_o[M];
            end
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = a_i;
        endcase
        zero_o = ~|res_o;
        neg_o  = res_o[M];
    end

endmodule

// File: rtl/datapath_param.sv
// Parametrised microprogrammed datapath: register file, R_in / z_out I/O
// registers, single-cycle ALU with registered flags and a bit-serial shifter
// that owns the RF write port and the flags while it is busy.
module datapath_param
    import datapath_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               NREGS     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              RW        = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RW-1:0]    fld_A,
    input  logic [RW-1:0]    fld_B,
    input  logic [RW-1:0]    fld_C,
    input  logic             ldRF,
    input  logic             selR_in,
    input  logic             ldR_in,
    input  logic             ldR_out,
    input  logic [2:0]       alu_op,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    output logic [WIDTH-1:0] z_out,
    output logic             cy,
    output logic             neg,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] r_in_q, z_out_q;
    flags_t           flags_q, flags_d;

    sh_state_e        state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             sh_cy_q, sh_cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    dest_q, dest_d;
    logic             dir_q, dir_d;     // 1 = shift right
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_val, b_val, alu_res, c_val, rf_wdata;
    logic [RW-1:0]    rf_waddr;
    logic             rf_wen;
    logic [NREGS-1:0] rf_we;
    logic             alu_cy, alu_neg, alu_zero, alu_ovf;
    logic             launch;

    assign a_val  = rf_q[fld_A];
    assign b_val  = rf_q[fld_B];
    assign c_val  = selR_in ? r_in_q : alu_res;
    assign busy   = (state_q != IDLE);
    assign launch = start && !busy && (alu_op == OP_SHL || alu_op == OP_SHR);

    alu_unit #(.WIDTH(WIDTH)) u_alu (
        .a_i    (a_val),
        .b_i    (b_val),
        .op_i   (alu_op),
        .res_o  (alu_res),
        .cy_o   (alu_cy),
        .neg_o  (alu_neg),
        .zero_o (alu_zero),
        .ovf_o  (alu_ovf)
    );

    // The shifter's commit takes the RF port; otherwise the microcode's C write
    always_comb begin
        rf_wen   = (state_q == WRITE) || (!busy && ldRF);
        rf_waddr = (state_q == WRITE) ? dest_q : fld_C;
        rf_wdata = (state_q == WRITE) ? sh_q : c_val;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_rf_we
            assign rf_we[gi] = rf_wen && (rf_waddr == RW'(gi));
        end
    endgenerate

    // Register file: written at the edge, so same-cycle reads see the old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (rf_we[i]) rf_q[i] <= rf_wdata;
            end
        end
    end

    // Flags follow the ALU when idle, the shift result on commit, else hold
    always_comb begin
        flags_d = flags_q;
        if (state_q == WRITE) begin
            flags_d = '{cy: sh_cy_q, neg: sh_q[WIDTH-1], zero: ~|sh_q, ovf: 1'b0};
        end else if (!busy) begin
            flags_d = '{cy: alu_cy, neg: alu_neg, zero: alu_zero, ovf: alu_ovf};
        end
    end

    // I/O registers and flags; R_in keeps loading even while the shifter runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_q  <= '0;
            z_out_q <= '0;
            flags_q <= '{cy: 1'b0, neg: 1'b0, zero: 1'b1, ovf: 1'b0};
        end else begin
            if (ldR_in) r_in_q <= x_in;
            if (ldR_out && !busy) z_out_q <= alu_res;
            flags_q <= flags_d;
        end
    end

    // Shifter next state: capture on launch, one bit per cycle, then commit
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        sh_cy_d = sh_cy_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    sh_d    = a_val;
                    sh_cy_d = 1'b0;
                    cnt_d   = b_val[CW-1:0];
                    dest_d  = fld_C;
                    dir_d   = (alu_op == OP_SHR);
                    state_d = (b_val[CW-1:0] == '0) ? WRITE : SHIFT;
                end
            end
            SHIFT: begin
                if (dir_q) begin
                    sh_cy_d = sh_q[0];
                    sh_d    = sh_q >> 1;
                end else begin
                    sh_cy_d = sh_q[WIDTH-1];
                    sh_d    = sh_q << 1;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = WRITE;
            end
            WRITE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifter state register; reset mid-shift drops the operation silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            sh_cy_q <= 1'b0;
            cnt_q   <= '0;
            dest_q  <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            sh_cy_q <= sh_cy_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign z_out = z_out_q;
    assign cy    = flags_q.cy;
    assign neg   = flags_q.neg;
    assign zero  = flags_q.zero;
    assign ovf   = flags_q.ovf;
    assign done  = done_q;

endmodule

// File: tb/tb_datapath_param.sv
// Bench for datapath_param (WIDTH=8, NREGS=8, RESET_VAL=0): a cycle-level
// behavioural model checked every cycle, plus hand-computed expectations.
module tb_datapath_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] fld_A, fld_B, fld_C, alu_op;
    logic       ldRF, selR_in, ldR_in, ldR_out, start;
    logic [7:0] x_in;
    logic [7:0] z_out;
    logic       cy, neg, zero, ovf, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    datapath_param #(.WIDTH(8), .NREGS(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst),
        .fld_A(fld_A), .fld_B(fld_B), .fld_C(fld_C),
        .ldRF(ldRF), .selR_in(selR_in), .ldR_in(ldR_in), .ldR_out(ldR_out),
        .alu_op(alu_op), .start(start), .x_in(x_in),
        .z_out(z_out), .cy(cy), .neg(neg), .zero(zero), .ovf(ovf),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // {cy, ovf, result} from plain integer arithmetic
    function automatic logic [9:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int s, ss;
        logic [7:0] r;
        bit c, v, arith;
        s = 0; ss = 0; r = a; c = 0; v = 0; arith = 0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); ss = int'($signed(a)) + int'($signed(b)); arith = 1; end
            3'd1: begin s = int'(a) - int'(b); ss = int'($signed(a)) - int'($signed(b)); arith = 1; end
            3'd5: begin s = int'(a) + 1;       ss = int'($signed(a)) + 1;               arith = 1; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: r = a;
        endcase
        if (arith) begin
            r = s[7:0];
            c = (s > 255) || (s < 0);
            v = (ss > 127) || (ss < -128);
        end
        return {c, v, r};
    endfunction

    // {last bit shifted out, shifted word}
    function automatic logic [8:0] shift_ref(input logic [2:0] op, input logic [7:0] a, input logic [2:0] n);
        int k;
        logic c;
        logic [7:0] r;
        k = int'(n);
        c = 1'b0;
        if (op == 3'd7) begin
            r = a >> k;
            if (k != 0) c = a[k-1];
        end else begin
            r = a << k;
            if (k != 0) c = a[8-k];
        end
        return {c, r};
    endfunction

    logic [7:0] m_rf [8];
    logic [7:0] m_rin, m_z, m_res;
    logic       m_cy, m_neg, m_zero, m_ovf, m_done, m_rcy;
    logic [2:0] m_dest;
    int         m_left;
    logic [9:0] m_alu;
    logic [8:0] m_shv;

    assign m_alu = alu_ref(alu_op, m_rf[fld_A], m_rf[fld_B]);
    assign m_shv = shift_ref(alu_op, m_rf[fld_A], m_rf[fld_B][2:0]);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_rf[i] <= 8'h00;
            m_rin <= 0; m_z <= 0; m_res <= 0; m_rcy <= 0; m_dest <= 0;
            m_cy <= 0; m_neg <= 0; m_zero <= 1; m_ovf <= 0; m_done <= 0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (ldR_in) m_rin <= x_in;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_rf[m_dest] <= m_res;
                    m_cy <= m_rcy; m_neg <= m_res[7]; m_zero <= (m_res == 0); m_ovf <= 1'b0;
                    m_done <= 1'b1;
                end
            end else begin
                m_cy <= m_alu[9]; m_ovf <= m_alu[8]; m_neg <= m_alu[7]; m_zero <= (m_alu[7:0] == 0);
                if (ldR_out) m_z <= m_alu[7:0];
                if (ldRF) m_rf[fld_C] <= selR_in ? m_rin : m_alu[7:0];
                if (start && alu_op >= 3'd6) begin
                    m_res  <= m_shv[7:0];
                    m_rcy  <= m_shv[8];
                    m_dest <= fld_C;
                    m_left <= int'(m_rf[fld_B][2:0]) + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("z_out", z_out, m_z);
            chk("cy",    cy,    m_cy);
            chk("neg",   neg,   m_neg);
            chk("zero",  zero,  m_zero);
            chk("ovf",   ovf,   m_ovf);
            chk("busy",  busy,  m_left > 0);
            chk("done",  done,  m_done);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        fld_A = 0; fld_B = 0; fld_C = 0; alu_op = 0;
        ldRF = 0; selR_in = 0; ldR_in = 0; ldR_out = 0; start = 0; x_in = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_rin(input logic [7:0] v);
        idle(); ldR_in = 1; x_in = v; step();
    endtask

    task automatic wr_rin(input logic [2:0] r);
        idle(); selR_in = 1; ldRF = 1; fld_C = r; step();
    endtask

    task automatic alu(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        idle(); alu_op = op; fld_A = a; fld_B = b; fld_C = c; ldRF = 1; ldR_out = 1; step();
    endtask

    // Read a register through the shift-opcode pass-through into z_out
    task automatic rd(input logic [2:0] r, output logic [7:0] v);
        idle(); alu_op = 3'd6; fld_A = r; ldR_out = 1; step(); v = z_out;
    endtask

    task automatic sh(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        idle(); alu_op = op; fld_A = a; fld_B = b; fld_C = c; start = 1; step();
    endtask

    // Count busy cycles until done; optionally hammer ignored strobes meanwhile
    task automatic wait_done(input bit noise, output int nbusy);
        bit got;
        got = 0; nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin got = 1; break; end
            if (busy) nbusy++;
            idle();
            if (noise) begin
                ldRF = 1; selR_in = 1; fld_C = 3'd7; ldR_out = 1; start = 1;
                alu_op = 3'd7; fld_A = 3'd1; fld_B = 3'd5; ldR_in = 1; x_in = 8'h5A;
            end
            step();
        end
        idle();
        chk("done_seen", got, 1);
    endtask

    initial begin
        logic [7:0] v;
        int nb;
        idle();
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_z", z_out, 8'h00);
        for (int r = 0; r < 8; r++) begin
            rd(3'(r), v);
            chk("rst_rf", v, 8'h00);
        end

        // ADD with carry
        load_rin(8'hF0); wr_rin(3'd1);
        load_rin(8'h20); wr_rin(3'd2);
        alu(3'd0, 3'd1, 3'd2, 3'd3);
        chk("add_res", z_out, 8'h10); chk("add_cy", cy, 1);
        chk("add_ovf", ovf, 0);       chk("add_zero", zero, 0);

        // SUB overflow and borrow
        load_rin(8'h80); wr_rin(3'd4);
        load_rin(8'h01); wr_rin(3'd5);
        alu(3'd1, 3'd4, 3'd5, 3'd6);
        chk("sub_res", z_out, 8'h7F); chk("sub_ovf", ovf, 1); chk("sub_cy", cy, 0);
        alu(3'd1, 3'd0, 3'd5, 3'd7);
        chk("borrow_res", z_out, 8'hFF); chk("borrow_cy", cy, 1); chk("borrow_neg", neg, 1);

        // SHL 0x81 by 3
        load_rin(8'h81); wr_rin(3'd1);
        load_rin(8'h03); wr_rin(3'd2);
        sh(3'd6, 3'd1, 3'd2, 3'd3);
        chk("shl_busy", busy, 1);
        wait_done(0, nb);
        chk("shl_nbusy", nb, 4); chk("shl_done_busy", busy, 0); chk("shl_cy", cy, 0);
        step();
        chk("shl_done_pulse", done, 0);
        rd(3'd3, v); chk("shl_res", v, 8'h08);

        // SHR 0x81 by 1
        sh(3'd7, 3'd1, 3'd5, 3'd4);
        wait_done(0, nb);
        chk("shr_nbusy", nb, 2); chk("shr_cy", cy, 1);
        rd(3'd4, v); chk("shr_res", v, 8'h40);

        // Shift by zero
        sh(3'd6, 3'd1, 3'd0, 3'd6);
        wait_done(0, nb);
        chk("sh0_nbusy", nb, 1); chk("sh0_cy", cy, 0);
        rd(3'd6, v); chk("sh0_res", v, 8'h81);

        // Ignored strobes while busy, then a back-to-back start on done
        sh(3'd6, 3'd1, 3'd2, 3'd7);
        wait_done(1, nb);
        chk("noise_nbusy", nb, 4);
        sh(3'd7, 3'd1, 3'd5, 3'd6);
        chk("b2b_busy", busy, 1);
        wait_done(0, nb);
        chk("b2b_nbusy", nb, 2);
        rd(3'd7, v); chk("noise_res", v, 8'h08);
        rd(3'd6, v); chk("b2b_res", v, 8'h40);
        wr_rin(3'd3);
        rd(3'd3, v); chk("rin_while_busy", v, 8'h5A);

        // Reset during the second busy cycle aborts the shift
        sh(3'd6, 3'd1, 3'd2, 3'd5);
        idle(); step();
        chk("abort_busy_before", busy, 1);
        #2 rst = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 0;
        repeat (6) begin
            step();
            chk("abort_no_done", done, 0);
        end
        rd(3'd5, v); chk("abort_dest", v, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule

// File: doc/datapath_param.md
# datapath_param

Parametrised successor of the 8-bit microprogrammed datapath: an N-register file, an R_in/z_out I/O register pair, a widened single-cycle ALU with registered flags, and a multi-cycle iterative shifter with a busy/done handshake. It sits under the microsequencer, which drives its field and load strobes every cycle and samples its flags for conditional branches.

## Interface
- WIDTH, 8, data word width (≥4)
- NREGS, 8, register-file depth (power of two, ≥2); RW = $clog2(NREGS)
- RESET_VAL, 0, reset contents of every RF entry
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- fld_A, fld_B  in  RW  RF read addresses for operands A and B
- fld_C  in  RW  RF write address
- ldRF  in  1  write C into RF[fld_C]
- selR_in  in  1  C source: 1 = R_in, 0 = alu_out
- ldR_in  in  1  R_in <= x_in
- ldR_out  in  1  z_out <= alu_out
- alu_op  in  3  operation code (datapath_pkg::alu_op_e)
- start  in  1  launch a shift op (SHL/SHR only)
- x_in  in  WIDTH  external input
- z_out  out  WIDTH  output register
- cy, neg, zero, ovf  out  1  registered flags
- busy  out  1  shifter running
- done  out  1  one-cycle pulse when the shift result is written

## Operation
- alu_op: ADD=0 A+B; SUB=1 A−B; AND=2; OR=3; XOR=4; INC=5 A+1; SHL=6; SHR=7 (logical).
- Arithmetic uses WIDTH+1 bits; cy = bit WIDTH (for SUB, cy = 1 means borrow). ovf = signed overflow for ADD/SUB/INC, else 0. Logic ops: cy=0, ovf=0.
- SHL/SHR with start=0: alu_out = A, cy=ovf=0 (pass-through).
- Flags update every non-busy cycle: zero = ~|alu_out, neg = alu_out[WIDTH-1].
- C = selR_in ? R_in : alu_out. An RF write takes effect at the edge, and the next cycle's reads see it.
- Shift launch (start=1, alu_op∈{SHL,SHR}, busy=0): capture sh=A, cnt=B[$clog2(WIDTH)-1:0], dest=fld_C, dir; busy<=1. start with any other op is ignored.
- While busy, each cycle:
  - cnt≠0: shift sh one bit (zero fill), shift-out bit into sh_cy, cnt−1.
  - cnt=0: RF[dest]<=sh, flags from sh (cy=sh_cy, 0 if the amount was 0; ovf=0), busy<=0, done<=1.
- While busy: ldRF, ldR_out, start and flag updates are ignored; ldR_in still works; the RF remains readable.

## Timing
- Reset values: RF all RESET_VAL, R_in=0, z_out=0, cy=neg=ovf=0, zero=1, busy=0, done=0, cnt=0.
- Single-cycle ops: operands are read combinationally, and the result, flags and z_out are registered at the same edge.
- Shift by n: start at edge k; busy high for cycles k+1 … k+n+1; RF write and done at edge k+n+2; done is high for exactly one cycle; busy=0 in that same cycle.
- A new start is accepted in the cycle done is high (back-to-back).
- rst during a shift aborts it: no RF write, and done is not asserted.
- ldRF with fld_C equal to fld_A in the same cycle: the read sees the old value.

## Structure
- datapath_pkg: alu_op_e enum, flag struct {cy,neg,zero,ovf}, shift FSM state enum (IDLE, SHIFT, WRITE).
- Sub-module alu_unit: combinational, parametrised WIDTH, returning alu_out plus flags. The shifter FSM and the RF live in the top module.

## Test plan
- Reset: after rst, read all regs → RESET_VAL; zero=1; busy=0; z_out=0.
- Load/ADD (WIDTH=8): R_in=0xF0→R1, R_in=0x20→R2, ADD R1,R2→R3 → R3=0x10, cy=1, ovf=0, zero=0.
- SUB borrow/overflow: 0x80−0x01 → 0x7F, ovf=1, cy=0. 0x00−0x01 → 0xFF, cy=1, neg=1.
- SHL: A=0x81, B=3, start → busy for 4 cycles, done 1 cycle, RF[dest]=0x08, cy=0. SHR of A=0x81 by 1 → 0x40, cy=1.
- Shift by 0: result = A, busy for 1 cycle, cy=0. ldRF/start asserted mid-shift → no effect. Back-to-back start on done → accepted.
- Reset mid-shift: assert rst at busy cycle 2 → busy=0, done never pulses, dest register unchanged at RESET_VAL.
